// File: rtl/decoder3to8_pkg.sv
// decoder3to8_pkg
//   Shared widths for the binary-to-one-hot decoder and a small helper that
//   tells whether a vector is all-zero or one-hot (never multi-hot).
//   Used by benches and by any checker that watches decoder outputs.
package decoder3to8_pkg;

    // Default decoder geometry: 3-bit select, 8 one-hot outputs.
    localparam int DEC_N     = 3;
    localparam int DEC_OUT_W = 8;

    // True when at most one bit of v is set. Callers zero-extend their
    // vector to 64 bits, so the helper covers any decoder with N <= 6.
    // An X anywhere in v yields X rather than a false "legal" result.
    function automatic logic is_onehot0(input logic [63:0] v);
        return ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/decoder3to8.sv
// decoder3to8
//   Binary-to-one-hot decoder with enable, default 3-to-8.
//   Provides a zero-latency combinational decode and a registered copy of it
//   (one cycle later) together with a registered valid flag.
//
//   Outputs are meaningful every cycle; there is no valid/ready handshake and
//   no backpressure. f_valid_q is a plain registered copy of e: when it is 1,
//   f_q holds the one-hot decode captured on the previous edge; when it is 0,
//   f_q is all zeros.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous, active-high reset (registered path only)
//   e          in   1      enable; 0 forces every output bit low
//   a          in   N      binary select
//   f          out  OUT_W  combinational decode: f[i] = e & (a == i)
//   f_q        out  OUT_W  f registered on clk
//   f_valid_q  out  1      e registered on clk
module decoder3to8
    import decoder3to8_pkg::*;
#(
    parameter int               N       = DEC_N,
    // Derived from N so the output width can never disagree with the select.
    localparam int              OUT_W   = 2**N,
    parameter logic [OUT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic [N-1:0]     a,
    output logic [OUT_W-1:0] f,
    output logic [OUT_W-1:0] f_q,
    output logic             f_valid_q
);

    // One equality compare per output bit. An X/Z on a or e propagates as X
    // through the compare, so it cannot masquerade as a clean one-hot.
    for (genvar i = 0; i < OUT_W; i++) begin : g_dec
        localparam logic [N-1:0] IDX = N'(i);
        assign f[i] = e & (a == IDX);
    end

    // Output register. Reset clears only this path; f never sees rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q       <= RST_VAL;
            f_valid_q <= 1'b0;
        end else begin
            f_q       <= f;
            f_valid_q <= e;
        end
    end

endmodule

// File: tb/tb_decoder3to8.sv
// tb_decoder3to8
//   Directed, table-driven bench for decoder3to8 (default N=3) plus a small
//   N=2 instance to show the width rules follow the parameter.
module tb_decoder3to8;
    import decoder3to8_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-width DUT
    logic       e;
    logic [2:0] a;
    logic [7:0] f;
    logic [7:0] f_q;
    logic       f_valid_q;

    decoder3to8 u_dut (
        .clk       (clk),
        .rst       (rst),
        .e         (e),
        .a         (a),
        .f         (f),
        .f_q       (f_q),
        .f_valid_q (f_valid_q)
    );

    // N=2 instance
    logic       e2;
    logic [1:0] a2;
    logic [3:0] f2;
    logic [3:0] f2_q;
    logic       f2_valid_q;

    decoder3to8 #(.N(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .e         (e2),
        .a         (a2),
        .f         (f2),
        .f_q       (f2_q),
        .f_valid_q (f2_valid_q)
    );

    // ------------------------------------------------------------------
    // Scoreboard: expected {f_valid_q, f_q} per driven cycle
    // ------------------------------------------------------------------
    logic [8:0] exp_q[$];
    logic [8:0] last_reg;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_invariants(input string name);
        logic legal_valid;
        check({name, " f one-hot"},   {8'b0, is_onehot0({56'b0, f})},   9'd1);
        check({name, " f_q one-hot"}, {8'b0, is_onehot0({56'b0, f_q})}, 9'd1);
        legal_valid = f_valid_q ? (f_q != 8'd0) : (f_q == 8'd0);
        check({name, " valid/f_q agree"}, {8'b0, legal_valid}, 9'd1);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        string      name;
        logic       rst;
        logic       e;
        logic [2:0] a;
        logic [7:0] exp_f;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic r, input logic en,
                                input logic [2:0] sel, input logic [7:0] ef);
        vec_t v;
        v.name = n; v.rst = r; v.e = en; v.a = sel; v.exp_f = ef;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Driver: apply one vector on the falling edge, check the combinational
    // output and the still-held register, then check the register after
    // the following rising edge against the scoreboard.
    // ------------------------------------------------------------------
    task automatic drive(input vec_t v);
        logic [8:0] exp_reg;
        @(negedge clk);
        rst = v.rst;
        e   = v.e;
        a   = v.a;
        #1;
        check({v.name, " f"}, {1'b0, f}, {1'b0, v.exp_f});
        check({v.name, " hold before edge"}, {f_valid_q, f_q}, last_reg);
        exp_q.push_back(v.rst ? 9'd0 : {v.e, v.exp_f});
        @(posedge clk);
        #1;
        exp_reg = exp_q.pop_front();
        check({v.name, " f_q"}, {f_valid_q, f_q}, exp_reg);
        check_invariants(v.name);
        last_reg = exp_reg;
    endtask

    // Watchdog: the bench only waits on clock edges, but keep a hard bound.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1);
    end

    initial begin
        // Hand-computed vectors
        vecs.push_back(mk("disable a=5", 1'b0, 1'b0, 3'd5, 8'b00000000));
        vecs.push_back(mk("sweep a=0",   1'b0, 1'b1, 3'd0, 8'b00000001));
        vecs.push_back(mk("sweep a=1",   1'b0, 1'b1, 3'd1, 8'b00000010));
        vecs.push_back(mk("sweep a=2",   1'b0, 1'b1, 3'd2, 8'b00000100));
        vecs.push_back(mk("sweep a=3",   1'b0, 1'b1, 3'd3, 8'b00001000));
        vecs.push_back(mk("sweep a=4",   1'b0, 1'b1, 3'd4, 8'b00010000));
        vecs.push_back(mk("sweep a=5",   1'b0, 1'b1, 3'd5, 8'b00100000));
        vecs.push_back(mk("sweep a=6",   1'b0, 1'b1, 3'd6, 8'b01000000));
        vecs.push_back(mk("sweep a=7",   1'b0, 1'b1, 3'd7, 8'b10000000));
        vecs.push_back(mk("toggle on",   1'b0, 1'b1, 3'd6, 8'b01000000));
        vecs.push_back(mk("toggle off",  1'b0, 1'b0, 3'd6, 8'b00000000));
        vecs.push_back(mk("rst prio 1",  1'b1, 1'b1, 3'd7, 8'b10000000));
        vecs.push_back(mk("rst prio 2",  1'b1, 1'b1, 3'd7, 8'b10000000));
        vecs.push_back(mk("rst release", 1'b0, 1'b1, 3'd7, 8'b10000000));
        vecs.push_back(mk("b2b a=3",     1'b0, 1'b1, 3'd3, 8'b00001000));
        vecs.push_back(mk("b2b a=5",     1'b0, 1'b1, 3'd5, 8'b00100000));
        vecs.push_back(mk("b2b a=0",     1'b0, 1'b1, 3'd0, 8'b00000001));

        // Reset with the decoder enabled: register must clear, f must not.
        rst = 1'b1;
        e   = 1'b1;
        a   = 3'd5;
        e2  = 1'b0;
        a2  = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset f_q",        {f_valid_q, f_q}, 9'd0);
        check("reset f live",     {1'b0, f}, {1'b0, 8'b00100000});
        check("reset N=2 f_q",    {f2_valid_q, 4'b0, f2_q}, 9'd0);
        last_reg = 9'd0;

        // Table sweep
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
        end

        // Mid-run reset pulse after active traffic: one edge clears, next
        // edge after release resumes tracking.
        drive(mk("pre-pulse a=2",  1'b0, 1'b1, 3'd2, 8'b00000100));
        drive(mk("pulse",          1'b1, 1'b1, 3'd4, 8'b00010000));
        drive(mk("post-pulse a=4", 1'b0, 1'b1, 3'd4, 8'b00010000));

        // N=2 instance
        @(negedge clk);
        rst = 1'b0;
        e2  = 1'b1;
        a2  = 2'b11;
        #1;
        check("N=2 a=3 f", {5'b0, f2}, {5'b0, 4'b1000});
        @(posedge clk);
        #1;
        check("N=2 a=3 f_q", {f2_valid_q, 4'b0, f2_q}, {1'b1, 4'b0, 4'b1000});
        @(negedge clk);
        a2 = 2'b00;
        #1;
        check("N=2 a=0 f", {5'b0, f2}, {5'b0, 4'b0001});
        e2 = 1'b0;
        #1;
        check("N=2 disabled f", {5'b0, f2}, 9'd0);
        @(posedge clk);
        #1;
        check("N=2 disabled f_q", {f2_valid_q, 4'b0, f2_q}, 9'd0);

        check("scoreboard drained", {8'b0, exp_q.size() == 0}, 9'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
